// File: rtl/sync_separator.sv
// Composite-sync separator: classifies low pulses on sync into line/frame strobes and tracks line timing lock.
// Define SYNCSEP_DEGLITCH_EN to insert a 3-tap majority filter ahead of the FSM (adds 2 clk to hs/vs latency).
module sync_separator #(
    parameter int HS_MIN     = 40,
    parameter int VS_MIN     = 540,
    parameter int LINE_NOM   = 1728,
    parameter int LINE_TOL   = 32,
    parameter int LOCK_LINES = 8,
    parameter int PAL_THRESH = 288
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        sync,
    output logic        hs,
    output logic        vs,
    output logic [8:0]  line,
    output logic [8:0]  lines,
    output logic [10:0] period,
    output logic        locked,
    output logic        pal
);
    // state  | meaning
    // S_HIGH | sync idle high, waiting for a falling edge
    // S_LOW  | inside a low pulse, width still below frame-sync length
    // S_VLOW | frame-sync pulse already reported, waiting for sync to return high
    typedef enum logic [1:0] {S_HIGH, S_LOW, S_VLOW} state_t;

    localparam int WW = $clog2(VS_MIN + 1);
    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam logic [WW-1:0] W_HS  = WW'(HS_MIN);
    localparam logic [WW-1:0] W_VS  = WW'(VS_MIN - 1);
    localparam logic [WW-1:0] W_ONE = WW'(1);
    localparam logic [GW-1:0] G_MAX = GW'(LOCK_LINES);
    localparam logic [GW-1:0] G_ONE = GW'(1);

    state_t        state;
    logic [WW-1:0] wcnt;
    logic [10:0]   pcnt;
    logic [GW-1:0] good;
    logic [GW-1:0] good_n;
    logic          skip;
    logic          sf;
    logic          hs_det;
    logic          vs_det;
    logic          in_tol;
    logic          timeout;
    logic [11:0]   p1;

`ifdef SYNCSEP_DEGLITCH_EN
    logic d1, d2;
    always_ff @(posedge clk) begin
        if (!nrst) begin
            d1 <= 1'b1;
            d2 <= 1'b1;
            sf <= 1'b1;
        end else begin
            d1 <= sync;
            d2 <= d1;
            sf <= (sync & d1) | (sync & d2) | (d1 & d2);
        end
    end
`else
    assign sf = sync;
`endif

    always_comb begin
        hs_det  = (state == S_LOW) && sf && (wcnt >= W_HS);
        vs_det  = (state == S_LOW) && !sf && (wcnt == W_VS);
        p1      = {1'b0, pcnt} + 12'd1;
        in_tol  = (p1 >= 12'(LINE_NOM - LINE_TOL)) && (p1 <= 12'(LINE_NOM + LINE_TOL));
        good_n  = (good == G_MAX) ? good : good + G_ONE;
        // fires on the cycle pcnt climbs onto 2047, independent of any clear in that cycle
        timeout = (pcnt == 11'd2046);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= S_HIGH;
            wcnt   <= '0;
            pcnt   <= '0;
            skip   <= 1'b1;
            good   <= '0;
            hs     <= 1'b0;
            vs     <= 1'b0;
            line   <= '0;
            lines  <= '0;
            period <= '0;
            locked <= 1'b0;
            pal    <= 1'b0;
        end else begin
            hs <= hs_det;
            vs <= vs_det;
            unique case (state)
                S_HIGH: if (!sf) begin
                    state <= S_LOW;
                    wcnt  <= W_ONE;
                end
                S_LOW: begin
                    if (sf)
                        state <= S_HIGH;
                    else if (wcnt == W_VS)
                        state <= S_VLOW;
                    else
                        wcnt <= wcnt + W_ONE;
                end
                S_VLOW: if (sf) state <= S_HIGH;
                default: state <= S_HIGH;
            endcase

            if (hs_det || vs_det)
                pcnt <= '0;
            else if (pcnt != 11'd2047)
                pcnt <= pcnt + 11'd1;

            if (hs_det) begin
                if (line != 9'd511) line <= line + 9'd1;
                if (skip) begin
                    skip <= 1'b0;
                end else begin
                    period <= p1[11] ? 11'd2047 : p1[10:0];
                    if (in_tol) begin
                        good <= good_n;
                        if (good_n == G_MAX) locked <= 1'b1;
                    end else begin
                        good   <= '0;
                        locked <= 1'b0;
                    end
                end
            end

            // the period straddling frame sync is never judged
            if (vs_det) begin
                lines <= line;
                pal   <= (line > 9'(PAL_THRESH));
                line  <= '0;
                skip  <= 1'b1;
            end

            if (timeout) begin
                period <= 11'd2047;
                locked <= 1'b0;
                good   <= '0;
                skip   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sync_separator.sv
// Randomized bench for sync_separator against a pulse/event-level reference model.
module tb_sync_separator;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        sync = 1'b1;
    logic        hs, vs, locked, pal;
    logic [8:0]  line, lines;
    logic [10:0] period;

    sync_separator dut (
        .clk(clk), .nrst(nrst), .sync(sync), .hs(hs), .vs(vs),
        .line(line), .lines(lines), .period(period), .locked(locked), .pal(pal)
    );

    always #5 clk = ~clk;

`ifdef SYNCSEP_DEGLITCH_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    int   n_pass = 0;
    int   n_chk  = 0;
    int   cur    = 0;
    int   obs_hs[$], obs_vs[$], exp_hs[$], exp_vs[$];
    logic hs_lk = 1'b0;

    int m_lc, m_good, m_period, m_line, m_lines;
    bit m_to, m_skip, m_locked, m_pal;

    // One input step: the posedge following this negedge is edge index cur.
    task automatic step(input logic s, input logic r);
        @(negedge clk);
        if (hs) begin
            obs_hs.push_back(cur - 1);
            hs_lk = locked;
        end
        if (vs) obs_vs.push_back(cur - 1);
        sync = s;
        nrst = r;
        cur++;
    endtask

    function automatic void m_reset(input int e);
        m_lc = e; m_to = 0; m_skip = 1; m_locked = 0; m_pal = 0;
        m_good = 0; m_period = 0; m_line = 0; m_lines = 0;
    endfunction

    function automatic void m_timeout();
        m_period = 2047; m_locked = 0; m_good = 0; m_skip = 1; m_to = 1;
    endfunction

    function automatic void m_adv(input int e);
        if (!m_to && e >= m_lc + 2047) m_timeout();
    endfunction

    function automatic void m_event(input int e, input bit is_vs);
        int gap;
        m_adv(e - 1);
        gap = e - m_lc;
        if (is_vs) begin
            exp_vs.push_back(e);
            m_lines = m_line;
            m_pal   = (m_line > 288);
            m_line  = 0;
            m_skip  = 1;
        end else begin
            exp_hs.push_back(e);
            if (m_line < 511) m_line++;
            if (m_skip) m_skip = 0;
            else begin
                m_period = gap;
                if (gap >= 1728 - 32 && gap <= 1728 + 32) begin
                    if (m_good < 8) m_good++;
                    if (m_good == 8) m_locked = 1;
                end else begin
                    m_good = 0;
                    m_locked = 0;
                end
            end
        end
        if (!m_to && gap == 2047) m_timeout();
        m_lc = e;
        m_to = 0;
    endfunction

    function automatic void m_pulse(input int s0, input int lo);
        if (lo >= 540) m_event(s0 + 539 + LAT, 1);
        else if (lo >= 40) m_event(s0 + lo + LAT, 0);
    endfunction

    function automatic logic [30:0] exp_vec();
        return {m_locked, m_pal, 9'(m_line), 9'(m_lines), 11'(m_period)};
    endfunction

    function automatic logic [30:0] dut_vec();
        return {locked, pal, line, lines, period};
    endfunction

    function automatic bit q_equal(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] != b[i]) return 0;
        return 1;
    endfunction

    // hi must be >= LAT+3 so the strobe is visible before the task returns
    task automatic drive_pulse(input int lo, input int hi);
        m_pulse(cur, lo);
        repeat (lo) step(1'b0, 1'b1);
        repeat (hi) step(1'b1, 1'b1);
        m_adv(cur - 2);
    endtask

    task automatic test_reset();
        int r;
        repeat (3) step(1'($urandom_range(0, 1)), 1'b0);
        r = cur - 1;
        step(1'b1, 1'b1);
        m_reset(r);
        n_chk++;
        if ({hs, vs, dut_vec()} !== 33'd0)
            $display("FAIL reset_outputs: got %h want 0", {hs, vs, dut_vec()});
        else n_pass++;
    endtask

    task automatic test_lines();
        for (int i = 1; i <= 12; i++) begin
            drive_pulse(108, 1620);
            n_chk++;
            if (dut_vec() !== exp_vec())
                $display("FAIL t1_state line %0d: dut=%h model=%h", i, dut_vec(), exp_vec());
            else n_pass++;
            n_chk++;
            if (locked !== (i >= 9) || period !== ((i >= 2) ? 11'd1728 : 11'd0))
                $display("FAIL t1_lock line %0d: locked=%b period=%0d", i, locked, period);
            else n_pass++;
            if (i == 9) begin
                n_chk++;
                if (hs_lk !== 1'b1) $display("FAIL t1_lock_at_hs: locked=%b at 9th hs want 1", hs_lk);
                else n_pass++;
            end
        end
        n_chk++;
        if (!q_equal(obs_hs, exp_hs) || obs_vs.size() != 0)
            $display("FAIL t1_strobes: hs %0d want %0d, vs %0d want 0", obs_hs.size(), exp_hs.size(), obs_vs.size());
        else n_pass++;
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 2; i++) begin
            int g = (i == 0) ? 20 : 39;
            int a = $urandom_range(200, 1400);
            drive_pulse(108, a);
            drive_pulse(g, 1620 - a - g);
            n_chk++;
            if (dut_vec() !== exp_vec())
                $display("FAIL t2_state glitch %0d: dut=%h model=%h", g, dut_vec(), exp_vec());
            else n_pass++;
            n_chk++;
            if (locked !== 1'b1 || period !== 11'd1728)
                $display("FAIL t2_lock glitch %0d: locked=%b period=%0d want 1/1728", g, locked, period);
            else n_pass++;
        end
        n_chk++;
        if (!q_equal(obs_hs, exp_hs))
            $display("FAIL t2_strobes: hs %0d want %0d", obs_hs.size(), exp_hs.size());
        else n_pass++;
    endtask

    task automatic test_unlock();
        int per[9];
        per[0] = 1696;
        per[1] = 1760;
        for (int k = 2; k < 8; k++) per[k] = $urandom_range(1696, 1760);
        per[8] = 1728;
        drive_pulse(108, 1692);
        for (int j = 0; j < 9; j++) begin
            drive_pulse(108, per[j] - 108);
            n_chk++;
            if (dut_vec() !== exp_vec())
                $display("FAIL t4_state step %0d: dut=%h model=%h", j, dut_vec(), exp_vec());
            else n_pass++;
            if (j == 0) begin
                n_chk++;
                if (period !== 11'd1800 || locked !== 1'b0 || hs_lk !== 1'b0)
                    $display("FAIL t4_unlock: period=%0d locked=%b at_hs=%b want 1800/0/0", period, locked, hs_lk);
                else n_pass++;
            end
            if (j == 7 || j == 8) begin
                n_chk++;
                if (locked !== (j == 8) || hs_lk !== (j == 8))
                    $display("FAIL t4_relock step %0d: locked=%b at_hs=%b", j, locked, hs_lk);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        int e0, seen;
        e0 = cur + 108 + LAT;
        m_pulse(cur, 108);
        repeat (108) step(1'b0, 1'b1);
        seen = -1;
        for (int k = 0; k < 3000; k++) begin
            step(1'b1, 1'b1);
            if (seen < 0 && period === 11'd2047) seen = cur - 2;
        end
        m_adv(cur - 2);
        n_chk++;
        if (seen !== e0 + 2047) $display("FAIL t5_timeout_edge: got %0d want %0d", seen, e0 + 2047);
        else n_pass++;
        n_chk++;
        if (period !== 11'd2047 || locked !== 1'b0 || dut_vec() !== exp_vec())
            $display("FAIL t5_timeout_state: dut=%h model=%h", dut_vec(), exp_vec());
        else n_pass++;
        drive_pulse(108, 1620);
        n_chk++;
        if (period !== 11'd2047 || dut_vec() !== exp_vec())
            $display("FAIL t5_skip: period=%0d want 2047, dut=%h model=%h", period, dut_vec(), exp_vec());
        else n_pass++;
        drive_pulse(108, 1620);
        n_chk++;
        if (period !== 11'd1728 || dut_vec() !== exp_vec())
            $display("FAIL t5_resume: period=%0d want 1728, dut=%h model=%h", period, dut_vec(), exp_vec());
        else n_pass++;
        n_chk++;
        if (!q_equal(obs_hs, exp_hs) || obs_vs.size() != 0)
            $display("FAIL t5_strobes: hs %0d want %0d, vs %0d", obs_hs.size(), exp_hs.size(), obs_vs.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        for (int it = 0; it < 2; it++) begin
            int pre  = $urandom_range(50, 200);
            int post = (it == 0) ? 199 : $urandom_range(10, 80);
            int r;
            repeat (pre) step(1'b0, 1'b1);
            r = cur;
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            m_reset(r);
            n_chk++;
            if ({hs, vs, dut_vec()} !== 33'd0)
                $display("FAIL t6_reset_outputs: got %h want 0", {hs, vs, dut_vec()});
            else n_pass++;
            m_pulse(r + 1, post);
            repeat (post - 1) step(1'b0, 1'b1);
            repeat (20) step(1'b1, 1'b1);
            m_adv(cur - 2);
            n_chk++;
            if (dut_vec() !== exp_vec() || !q_equal(obs_hs, exp_hs) || !q_equal(obs_vs, exp_vs))
                $display("FAIL t6_after post=%0d: dut=%h model=%h hs %0d want %0d",
                         post, dut_vec(), exp_vec(), obs_hs.size(), exp_hs.size());
            else n_pass++;
        end
    endtask

    task automatic test_frame();
        for (int rep = 0; rep < 2; rep++) begin
            int nl = (rep == 0) ? 312 : 264;
            int s0;
            for (int i = 0; i < nl; i++)
                drive_pulse((i == 0) ? 40 : $urandom_range(40, 44), $urandom_range(6, 9));
            n_chk++;
            if (dut_vec() !== exp_vec())
                $display("FAIL t3_before_vs rep %0d: dut=%h model=%h", rep, dut_vec(), exp_vec());
            else n_pass++;
            s0 = cur;
            drive_pulse(600, 20);
            n_chk++;
            if (obs_vs.size() !== rep + 1 || obs_vs[obs_vs.size() - 1] !== s0 + 539 + LAT)
                $display("FAIL t3_vs_time rep %0d: count=%0d want %0d", rep, obs_vs.size(), rep + 1);
            else n_pass++;
            n_chk++;
            if (lines !== 9'(nl) || pal !== (rep == 0) || line !== 9'd0)
                $display("FAIL t3_frame rep %0d: lines=%0d pal=%b line=%0d want %0d/%b/0",
                         rep, lines, pal, line, nl, rep == 0);
            else n_pass++;
            n_chk++;
            if (dut_vec() !== exp_vec() || !q_equal(obs_hs, exp_hs) || !q_equal(obs_vs, exp_vs))
                $display("FAIL t3_model rep %0d: dut=%h model=%h hs %0d want %0d",
                         rep, dut_vec(), exp_vec(), obs_hs.size(), exp_hs.size());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lines();
        test_glitch();
        test_unlock();
        test_timeout();
        test_reset_mid_pulse();
        test_reset();
        test_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end
endmodule
